// File: rtl/pcie_rq_arbiter.sv
// rtl/pcie_rq_arbiter.sv - packet-atomic round-robin arbiter of two RQ streams into a 2-deep FIFO
module pcie_rq_arbiter #(
    parameter int C_DATA_WIDTH        = 128,
    parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
    parameter int AXI4_RQ_TUSER_WIDTH = 62
) (
    input  logic                           user_clk,
    input  logic                           user_reset_n,
    input  logic                           user_lnk_up,

    input  logic [C_DATA_WIDTH-1:0]        s0_axis_rq_tdata,
    input  logic [KEEP_WIDTH-1:0]          s0_axis_rq_tkeep,
    input  logic [AXI4_RQ_TUSER_WIDTH-1:0] s0_axis_rq_tuser,
    input  logic                           s0_axis_rq_tlast,
    input  logic                           s0_axis_rq_tvalid,
    output logic [3:0]                     s0_axis_rq_tready,

    input  logic [C_DATA_WIDTH-1:0]        s1_axis_rq_tdata,
    input  logic [KEEP_WIDTH-1:0]          s1_axis_rq_tkeep,
    input  logic [AXI4_RQ_TUSER_WIDTH-1:0] s1_axis_rq_tuser,
    input  logic                           s1_axis_rq_tlast,
    input  logic                           s1_axis_rq_tvalid,
    output logic [3:0]                     s1_axis_rq_tready,

    output logic [C_DATA_WIDTH-1:0]        m_axis_rq_tdata,
    output logic [KEEP_WIDTH-1:0]          m_axis_rq_tkeep,
    output logic [AXI4_RQ_TUSER_WIDTH-1:0] m_axis_rq_tuser,
    output logic                           m_axis_rq_tlast,
    output logic                           m_axis_rq_tvalid,
    input  logic [3:0]                     m_axis_rq_tready,

    output logic [15:0]                    pkt_cnt0,
    output logic [15:0]                    pkt_cnt1,
    output logic [7:0]                     abort_cnt
);

    localparam int EW = C_DATA_WIDTH + KEEP_WIDTH + AXI4_RQ_TUSER_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t        state, state_nxt;
    logic          last_grant;
    logic          rst_done;
    logic [1:0]    count;
    logic [EW-1:0] ent0, ent1, din;
    logic          s0_rdy, s1_rdy, s0_xfer, s1_xfer, push, pop;
    logic          unused_tready;

    assign unused_tready = ^m_axis_rq_tready[3:1];

    assign s0_rdy  = user_lnk_up && (state == GRANT0) && (count != 2'd2);
    assign s1_rdy  = user_lnk_up && (state == GRANT1) && (count != 2'd2);
    assign s0_axis_rq_tready = {4{s0_rdy}};
    assign s1_axis_rq_tready = {4{s1_rdy}};
    assign s0_xfer = s0_axis_rq_tvalid && s0_rdy;
    assign s1_xfer = s1_axis_rq_tvalid && s1_rdy;
    assign push    = s0_xfer || s1_xfer;

    assign m_axis_rq_tvalid = user_lnk_up && (count != 2'd0);
    assign pop = m_axis_rq_tvalid && m_axis_rq_tready[0];

    assign din = (state == GRANT1) ?
        {s1_axis_rq_tdata, s1_axis_rq_tkeep, s1_axis_rq_tuser, s1_axis_rq_tlast} :
        {s0_axis_rq_tdata, s0_axis_rq_tkeep, s0_axis_rq_tuser, s0_axis_rq_tlast};

    // ent0 is the FIFO head and drives the outputs directly, so fields hold after the last pop
    assign {m_axis_rq_tdata, m_axis_rq_tkeep, m_axis_rq_tuser, m_axis_rq_tlast} = ent0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // rst_done keeps the first grant off the first edge after reset release
                if (rst_done) begin
                    if (s0_axis_rq_tvalid && s1_axis_rq_tvalid)
                        state_nxt = last_grant ? GRANT0 : GRANT1;
                    else if (s0_axis_rq_tvalid)
                        state_nxt = GRANT0;
                    else if (s1_axis_rq_tvalid)
                        state_nxt = GRANT1;
                end
            end
            GRANT0:  if (s0_xfer && s0_axis_rq_tlast) state_nxt = IDLE;
            GRANT1:  if (s1_xfer && s1_axis_rq_tlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!user_lnk_up)
            state_nxt = IDLE;
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            rst_done   <= 1'b0;
            pkt_cnt0   <= '0;
            pkt_cnt1   <= '0;
            abort_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            rst_done <= 1'b1;
            if (s0_xfer && s0_axis_rq_tlast) begin
                last_grant <= 1'b0;
                pkt_cnt0   <= pkt_cnt0 + 16'd1;
            end
            if (s1_xfer && s1_axis_rq_tlast) begin
                last_grant <= 1'b1;
                pkt_cnt1   <= pkt_cnt1 + 16'd1;
            end
            if (!user_lnk_up && (state != IDLE) && (abort_cnt != 8'hFF))
                abort_cnt <= abort_cnt + 8'd1;
        end
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            count <= 2'd0;
            ent0  <= '0;
            ent1  <= '0;
        end else if (!user_lnk_up) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) ent0 <= din;
                    else               ent1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) ent0 <= ent1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        ent0 <= din;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_rq_arbiter.sv
// tb/tb_pcie_rq_arbiter.sv - scoreboard bench for pcie_rq_arbiter
module tb_pcie_rq_arbiter;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   keep;
        logic [61:0]  user;
        logic         last;
    } beat_t;

    logic         user_clk = 1'b0;
    logic         user_reset_n;
    logic         user_lnk_up;
    logic [127:0] s0_tdata, s1_tdata, m_tdata;
    logic [3:0]   s0_tkeep, s1_tkeep, m_tkeep;
    logic [61:0]  s0_tuser, s1_tuser, m_tuser;
    logic         s0_tlast, s1_tlast, m_tlast;
    logic         s0_tvalid, s1_tvalid, m_tvalid;
    logic [3:0]   s0_tready, s1_tready, m_tready;
    logic [15:0]  pkt_cnt0, pkt_cnt1;
    logic [7:0]   abort_cnt;

    beat_t        sb[$];
    int           vectors = 0;
    int           errors  = 0;
    int           first_port;
    bit           mon_en = 1'b1;
    logic [15:0]  exp_cnt0 = 16'd0, exp_cnt1 = 16'd0;
    logic [7:0]   exp_abort = 8'd0;

    always #5 user_clk = ~user_clk;

    pcie_rq_arbiter dut (
        .user_clk          (user_clk),
        .user_reset_n      (user_reset_n),
        .user_lnk_up       (user_lnk_up),
        .s0_axis_rq_tdata  (s0_tdata),
        .s0_axis_rq_tkeep  (s0_tkeep),
        .s0_axis_rq_tuser  (s0_tuser),
        .s0_axis_rq_tlast  (s0_tlast),
        .s0_axis_rq_tvalid (s0_tvalid),
        .s0_axis_rq_tready (s0_tready),
        .s1_axis_rq_tdata  (s1_tdata),
        .s1_axis_rq_tkeep  (s1_tkeep),
        .s1_axis_rq_tuser  (s1_tuser),
        .s1_axis_rq_tlast  (s1_tlast),
        .s1_axis_rq_tvalid (s1_tvalid),
        .s1_axis_rq_tready (s1_tready),
        .m_axis_rq_tdata   (m_tdata),
        .m_axis_rq_tkeep   (m_tkeep),
        .m_axis_rq_tuser   (m_tuser),
        .m_axis_rq_tlast   (m_tlast),
        .m_axis_rq_tvalid  (m_tvalid),
        .m_axis_rq_tready  (m_tready),
        .pkt_cnt0          (pkt_cnt0),
        .pkt_cnt1          (pkt_cnt1),
        .abort_cnt         (abort_cnt)
    );

    task automatic check_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sends one packet; beats are pushed to the scoreboard in the cycle they are accepted
    task automatic send_pkt(input int port, input int nbeats, input bit final_last, input logic [7:0] id);
        beat_t bt;
        bit    ok;
        for (int b = 0; b < nbeats; b++) begin
            bt.data = {8'(port), id, 8'(b), $urandom(), $urandom(), $urandom(), 8'h00};
            bt.keep = (b == nbeats - 1) ? 4'(1 + $urandom_range(0, 14)) : 4'hF;
            bt.user = 62'({$urandom(), $urandom()});
            bt.last = final_last && (b == nbeats - 1);
            if (port == 0) begin
                {s0_tdata, s0_tkeep, s0_tuser, s0_tlast} = bt;
                s0_tvalid = 1'b1;
            end else begin
                {s1_tdata, s1_tkeep, s1_tuser, s1_tlast} = bt;
                s1_tvalid = 1'b1;
            end
            ok = 1'b0;
            for (int t = 0; t < 64 && !ok; t++) begin
                @(negedge user_clk);
                if ((port == 0) ? s0_tready[0] : s1_tready[0]) begin
                    ok = 1'b1;
                    sb.push_back(bt);
                    if (first_port < 0) first_port = port;
                    if (bt.last) begin
                        if (port == 0) exp_cnt0 = exp_cnt0 + 16'd1;
                        else           exp_cnt1 = exp_cnt1 + 16'd1;
                    end
                end
                @(posedge user_clk);
                #1;
            end
            if (!ok) check_vec("accept_timeout", 0, 1);
        end
        if (port == 0) s0_tvalid = 1'b0;
        else           s1_tvalid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && sb.size() != 0; t++) @(posedge user_clk);
        #1;
        check_vec("drain", sb.size(), 0);
    endtask

    always @(negedge user_clk) begin
        if (user_reset_n && mon_en) begin
            check_vec("rdy_form",
                      {(s0_tready != 4'h0) && (s1_tready != 4'h0),
                       (s0_tready != 4'h0) && (s0_tready != 4'hF),
                       (s1_tready != 4'h0) && (s1_tready != 4'hF)}, 3'b000);
            if (m_tvalid && m_tready[0]) begin
                if (sb.size() == 0) begin
                    check_vec("unexpected_beat", m_tdata, 0);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    check_vec("m_tdata", m_tdata, e.data);
                    check_vec("m_ctl", {m_tkeep, m_tuser, m_tlast}, {e.keep, e.user, e.last});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        user_reset_n = 1'b0;
        user_lnk_up  = 1'b1;
        m_tready     = 4'hF;
        {s0_tdata, s0_tkeep, s0_tuser, s0_tlast, s0_tvalid} = '0;
        {s1_tdata, s1_tkeep, s1_tuser, s1_tlast, s1_tvalid} = '0;
        first_port = -1;
        #1;
        check_vec("rst_mvalid", m_tvalid, 0);
        check_vec("rst_mdata", {m_tdata, m_tkeep, m_tuser, m_tlast}, 0);
        check_vec("rst_ready", {s0_tready, s1_tready}, 0);
        check_vec("rst_cnts", {pkt_cnt0, pkt_cnt1, abort_cnt}, 0);
        #11 user_reset_n = 1'b1;
        repeat (2) @(posedge user_clk);
        #1;

        // tie after reset: port 0 first, whole packets, then port 1
        first_port = -1;
        fork
            send_pkt(0, 2, 1'b1, 8'h10);
            send_pkt(1, 2, 1'b1, 8'h11);
        join
        drain();
        check_vec("tie_first", first_port, 0);
        check_vec("tie_cnt0", pkt_cnt0, exp_cnt0);
        check_vec("tie_cnt1", pkt_cnt1, exp_cnt1);

        // second tie: round-robin now favours port 0 again (port 1 was last)
        first_port = -1;
        fork
            send_pkt(1, 1, 1'b1, 8'h20);
            send_pkt(0, 3, 1'b1, 8'h21);
        join
        drain();
        check_vec("rr_first", first_port, 0);

        // single-beat CfgRd, visible the cycle after acceptance
        send_pkt(0, 1, 1'b1, 8'h30);
        check_vec("cfgrd_lat", m_tvalid, 1);
        drain();
        check_vec("cfgrd_cnt0", pkt_cnt0, exp_cnt0);

        // backpressure with only the unused ready bits high
        m_tready = 4'hE;
        fork
            send_pkt(1, 4, 1'b1, 8'h40);
            begin
                repeat (5) @(posedge user_clk);
                @(negedge user_clk);
                check_vec("bp_s1_ready", s1_tready, 4'h0);
                check_vec("bp_mvalid", m_tvalid, 1);
                @(posedge user_clk);
                #1 m_tready = 4'hF;
            end
        join
        drain();
        check_vec("bp_cnt1", pkt_cnt1, exp_cnt1);

        // link drop after beat 2 of a port-1 packet
        send_pkt(1, 2, 1'b0, 8'h50);
        user_lnk_up = 1'b0;
        #1;
        sb.delete();
        check_vec("ld_mvalid", m_tvalid, 0);
        check_vec("ld_ready", {s0_tready, s1_tready}, 0);
        exp_abort = exp_abort + 8'd1;
        @(posedge user_clk);
        #1;
        check_vec("ld_abort", abort_cnt, exp_abort);
        @(posedge user_clk);
        #1 user_lnk_up = 1'b1;
        #1;
        check_vec("ld_fifo_clear", m_tvalid, 0);
        check_vec("ld_idle", s1_tready, 4'h0);
        send_pkt(1, 4, 1'b1, 8'h51);
        drain();
        check_vec("ld_cnt1", pkt_cnt1, exp_cnt1);
        check_vec("ld_abort_hold", abort_cnt, exp_abort);

        // wrap of pkt_cnt0 from a preloaded value
        @(negedge user_clk);
        force dut.pkt_cnt0 = 16'hFFFE;
        #1 release dut.pkt_cnt0;
        exp_cnt0 = 16'hFFFE;
        send_pkt(0, 1, 1'b1, 8'h60);
        drain();
        check_vec("wrap_ffff", pkt_cnt0, exp_cnt0);
        send_pkt(0, 2, 1'b1, 8'h61);
        drain();
        check_vec("wrap_zero", pkt_cnt0, 16'h0000);

        // asynchronous reset in the middle of a packet
        mon_en = 1'b0;
        {s0_tdata, s0_tkeep, s0_tuser, s0_tlast} = {128'hA5A5, 4'hF, 62'h3, 1'b0};
        s0_tvalid = 1'b1;
        repeat (3) @(posedge user_clk);
        #3 user_reset_n = 1'b0;
        #1;
        sb.delete();
        exp_cnt0 = 16'd0;
        exp_cnt1 = 16'd0;
        exp_abort = 8'd0;
        check_vec("arst_mvalid", m_tvalid, 0);
        check_vec("arst_mdata", {m_tdata, m_tkeep, m_tuser, m_tlast}, 0);
        check_vec("arst_ready", {s0_tready, s1_tready}, 0);
        check_vec("arst_cnts", {pkt_cnt0, pkt_cnt1, abort_cnt}, 0);
        #2 user_reset_n = 1'b1;
        @(posedge user_clk);
        #1;
        check_vec("rel_edge1", s0_tready, 4'h0);
        @(posedge user_clk);
        #1;
        check_vec("rel_edge2", s0_tready, 4'hF);
        s0_tvalid = 1'b0;
        repeat (2) @(posedge user_clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
